// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its settle timer.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEFAULT_N_IN = 4;

    // Wide enough to hold SETTLE_CYCLES-1 for the largest legal setting (15).
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter; expired is high once the count reaches zero.
module tt_settle_timer
    import tt_sweep_pkg::*;
#(
    parameter int W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector through two implementations of one boolean function,
// records both truth tables and flags disagreement. Optional TT_SWEEP_MISMATCH_LOG_EN
// adds mismatch count / first index / flag outputs.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int N_IN          = DEFAULT_N_IN,
    parameter int SETTLE_CYCLES = 1,
    localparam int T            = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] vec_o,
    input  logic            s1_i,
    input  logic            s2_i,
    output logic            busy,
    output logic            done,
    output logic [T-1:0]    table1,
    output logic [T-1:0]    table2,
    output logic            equiv
`ifdef TT_SWEEP_MISMATCH_LOG_EN
    ,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_mismatch,
    output logic            has_mismatch
`endif
);

    localparam logic [N_IN-1:0]     LAST_VEC    = {N_IN{1'b1}};
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t state, next_state;
    logic   accept;
    logic   sample;
    logic   finish;
    logic   timer_load;
    logic   timer_en;
    logic   expired;

    tt_settle_timer #(
        .W (SETTLE_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (SETTLE_LOAD),
        .en       (timer_en),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        sample     = 1'b0;
        finish     = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        accept     = 1'b1;
                        timer_load = 1'b1;
                        next_state = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    timer_en = 1'b1;
                    if (expired) begin
                        next_state = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    sample = 1'b1;
                    if (vec_o == LAST_VEC) begin
                        next_state = ST_DONE;
                    end else begin
                        timer_load = 1'b1;
                        next_state = ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    finish     = 1'b1;
                    next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered off the control strobes, so done/busy/equiv change one
    // edge after the DONE state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_o  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            table1 <= '0;
            table2 <= '0;
            equiv  <= 1'b0;
        end else begin
            done <= finish;
            if (abort) begin
                busy  <= 1'b0;
                equiv <= 1'b0;
            end else if (accept) begin
                vec_o  <= '0;
                busy   <= 1'b1;
                table1 <= '0;
                table2 <= '0;
                equiv  <= 1'b0;
            end else begin
                if (sample) begin
                    table1[vec_o] <= s1_i;
                    table2[vec_o] <= s2_i;
                    if (vec_o != LAST_VEC) begin
                        vec_o <= vec_o + 1'b1;
                    end
                end
                if (finish) begin
                    busy  <= 1'b0;
                    equiv <= (table1 == table2);
                end
            end
        end
    end

`ifdef TT_SWEEP_MISMATCH_LOG_EN
    localparam logic [N_IN:0] CNT_MAX = {1'b1, {N_IN{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            has_mismatch   <= 1'b0;
        end else if (accept) begin
            mismatch_cnt   <= '0;
            first_mismatch <= '0;
            has_mismatch   <= 1'b0;
        end else if (sample && (s1_i != s2_i)) begin
            if (mismatch_cnt != CNT_MAX) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end
            if (!has_mismatch) begin
                has_mismatch   <= 1'b1;
                first_mismatch <= vec_o;
            end
        end
    end
`endif

endmodule
